encoder_cb_scheduler: RTL and testbench
=======================================

// Module: encoder_cb_scheduler
// PURPOSE
//  Sequences code blocks from the 10-bit CBS FIFO ({data[7:0],blocksize,start}) into the parallel turbo
//  encoder. Owns the FIFO read side, holds each block until interleaver and encoder are free, then issues
//  exactly one block (132 or 768 bytes) per enc_start. Flags framing errors.
//  Sits between fifo_10 and encoder_top_parallel; replaces the encoder's direct FIFO read control.
// PARAMETERS
//  SMALL_BYTES  132  bytes per block when blocksize=0 (1056-bit code block)
//  LARGE_BYTES  768  bytes per block when blocksize=1 (6144-bit code block)
//  CNT_W        10   byte-counter width; must hold LARGE_BYTES
// PORTS
//  clock          in   1      single system clock, rising edge
//  reset          in   1      asynchronous, active-low reset
//  fifo_q         in   10     FIFO read data: [0]=start, [1]=blocksize, [9:2]=data byte
//  fifo_empty     in   1      FIFO empty
//  fifo_rdreq     out  1      FIFO read request; data valid on fifo_q the following cycle
//  int_ready      in   1      interleaver can accept a new block
//  enc_busy       in   1      encoder still processing/outputting the previous block
//  enc_start      out  1      one-cycle pulse, coincident with the first byte of a block
//  enc_blocksize  out  1      size of current block; held stable from enc_start to block end
//  enc_din        out  8      data byte to encoder
//  enc_din_valid  out  1      enc_din valid this cycle
//  block_active   out  1      high from enc_start through last byte of block
//  sched_err      out  1      sticky framing-error flag; cleared only by reset
// BEHAVIOUR
//  Reset (reset=0, async): state IDLE; all outputs 0; counters 0. FIFO is not cleared by this block.
//  FIFO is non-show-ahead: rdreq at cycle t -> fifo_q valid at t+1. Never assert rdreq when fifo_empty=1.
//  N = blocksize ? LARGE_BYTES : SMALL_BYTES, latched from the header word.
//  IDLE:   if !fifo_empty -> rdreq one cycle, go HDR.
//  HDR:    inspect fifo_q. start=1 -> latch blocksize and byte0, go WAIT_RES.
//          start=0 -> stray word: discard, set sched_err, go IDLE.
//  WAIT_RES: hold byte0; when int_ready=1 && enc_busy=0 -> enc_start=1, enc_din_valid=1, enc_din=byte0,
//          block_active=1, sent=1, issued=1, go STREAM. Min latency header-visible -> enc_start = 1 cycle.
//  STREAM: rdreq = !fifo_empty && issued<N; issued++ on rdreq. Each cycle after a rdreq: enc_din=fifo_q[9:2],
//          enc_din_valid=1, sent++. Empty FIFO inserts valid gaps (no timeout). When sent reaches N on a
//          valid byte: block_active drops next cycle, go IDLE. No rdreq issued beyond N per block.
//  Mid-block start=1 on fifo_q: byte not forwarded, sched_err set, block_active drops, word becomes header
//   of the next block (latch blocksize/byte0), go WAIT_RES. Truncated block is not padded.
//  Mid-block blocksize bit differing from latched value: sched_err set; byte forwarded; latched N governs.
//  enc_busy/int_ready changes during STREAM are ignored; they gate only enc_start.
//  Back-to-back blocks: next header may be fetched in IDLE the cycle after last byte; enc_start waits on resources.
//  Reset mid-block: immediate return to IDLE, outputs 0; partially read block data is lost.
// CONFIGURATION
//  CB_SCHED_STATS_EN defined: adds output blocks_done [15:0] (wraps at 65535->0) counting completed
//   full-length blocks (incremented on last byte), and err_count [7:0] (saturates at 255) counting framing
//   errors; both reset to 0.
//  Not defined: ports and counters absent; all other behaviour identical.
// TESTING
//  1 Reset: reset=0 mid-STREAM -> all outputs 0 same cycle; after release with FIFO empty, rdreq stays 0.
//  2 One small block (132 words, first start=1,bs=0), int_ready=1, enc_busy=0 -> one enc_start pulse,
//    exactly 132 enc_din_valid, bytes in order, enc_blocksize=0, sched_err=0, 132 rdreqs total.
//  3 Large block (768 words, bs=1) with enc_busy=1 for 20 cycles after header -> enc_start waits,
//    fires cycle after enc_busy=0; 768 bytes; no rdreq while in WAIT_RES.
//  4 FIFO underrun: write block in bursts of 10 words with 5-cycle gaps -> no rdreq while empty,
//    valid gaps, byte count still 132, no error.
//  5 Errors: leading word start=0 -> discarded, sched_err=1; start=1 at byte 50 of small block ->
//    49... truncated after 50 bytes, new block started, err_count=2 with CB_SCHED_STATS_EN.
//  6 Back-to-back: two small blocks pre-loaded, resources free -> second enc_start <=3 cycles after
//    first block's last byte; blocks_done=2.

Source files
------------

// File: rtl/encoder_cb_scheduler_if.sv
// Handshake bundle linking the CBS FIFO read side, the code-block scheduler and the parallel turbo encoder.
// master = scheduler side, slave = FIFO/encoder environment side.
interface encoder_cb_scheduler_if;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned WORD_W = DATA_W + 2;

  logic [WORD_W-1:0] fifo_q;
  logic              fifo_empty;
  logic              fifo_rdreq;
  logic              int_ready;
  logic              enc_busy;
  logic              enc_start;
  logic              enc_blocksize;
  logic [DATA_W-1:0] enc_din;
  logic              enc_din_valid;
  logic              block_active;
  logic              sched_err;

  modport master (
    input  fifo_q, fifo_empty, int_ready, enc_busy,
    output fifo_rdreq, enc_start, enc_blocksize, enc_din, enc_din_valid, block_active, sched_err
  );

  modport slave (
    output fifo_q, fifo_empty, int_ready, enc_busy,
    input  fifo_rdreq, enc_start, enc_blocksize, enc_din, enc_din_valid, block_active, sched_err
  );
endinterface

// File: rtl/encoder_cb_scheduler.sv
// Code-block scheduler: pulls framed words from the CBS FIFO and issues one 132/768-byte block per enc_start.
// Optional CB_SCHED_STATS_EN adds blocks_done / err_count statistics outputs.
module encoder_cb_scheduler #(
  parameter int unsigned SMALL_BYTES = 132,
  parameter int unsigned LARGE_BYTES = 768,
  parameter int unsigned CNT_W       = 10
) (
  input  logic                   clock,
  input  logic                   reset,
  encoder_cb_scheduler_if.master sched_io
`ifdef CB_SCHED_STATS_EN
  ,
  output logic [15:0]            blocks_done,
  output logic [7:0]             err_count
`endif
);

  localparam int unsigned DATA_W = 8;

  typedef enum logic [1:0] {
    S_IDLE,
    S_HDR,
    S_WAIT_RES,
    S_STREAM
  } state_e;

  state_e             state_q, state_d;
  logic               bs_q, bs_d;
  logic [DATA_W-1:0]  byte0_q, byte0_d;
  logic [CNT_W-1:0]   issued_q, issued_d;
  logic [CNT_W-1:0]   sent_q, sent_d;
  logic               err_q, err_d;
  logic               rd_pend_q;
  logic               enc_start_q, enc_start_d;
  logic               enc_bs_q, enc_bs_d;
  logic [DATA_W-1:0]  enc_din_q, enc_din_d;
  logic               enc_valid_q, enc_valid_d;
  logic               active_q, active_d;

  logic               rdreq_c;
  logic               issue_c;
  logic               issue_bs_c;
  logic [DATA_W-1:0]  issue_byte_c;
  logic               err_evt_c;
  logic               res_free_c;
  logic               last_c;
  logic [CNT_W-1:0]   n_c;

  assign n_c        = bs_q ? CNT_W'(LARGE_BYTES) : CNT_W'(SMALL_BYTES);
  assign res_free_c = sched_io.int_ready && !sched_io.enc_busy;
  // Final byte of a full-length block is on fifo_q this cycle.
  assign last_c     = (state_q == S_STREAM) && rd_pend_q && !sched_io.fifo_q[0] &&
                      ((sent_q + CNT_W'(1)) == n_c);

  // Next-state and registered-output decode.
  always_comb begin
    state_d      = state_q;
    bs_d         = bs_q;
    byte0_d      = byte0_q;
    issued_d     = issued_q;
    sent_d       = sent_q;
    err_d        = err_q;
    enc_start_d  = 1'b0;
    enc_bs_d     = enc_bs_q;
    enc_din_d    = enc_din_q;
    enc_valid_d  = 1'b0;
    active_d     = active_q;
    rdreq_c      = 1'b0;
    issue_c      = 1'b0;
    issue_bs_c   = bs_q;
    issue_byte_c = byte0_q;
    err_evt_c    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        active_d = 1'b0;
        if (!sched_io.fifo_empty) begin
          rdreq_c = 1'b1;
          state_d = S_HDR;
        end
      end

      S_HDR: begin
        active_d = 1'b0;
        if (sched_io.fifo_q[0]) begin
          bs_d    = sched_io.fifo_q[1];
          byte0_d = sched_io.fifo_q[9:2];
          if (res_free_c) begin
            issue_c      = 1'b1;
            issue_bs_c   = sched_io.fifo_q[1];
            issue_byte_c = sched_io.fifo_q[9:2];
          end else begin
            state_d = S_WAIT_RES;
          end
        end else begin
          err_evt_c = 1'b1;
          state_d   = S_IDLE;
        end
      end

      S_WAIT_RES: begin
        if (res_free_c) begin
          issue_c = 1'b1;
        end
      end

      S_STREAM: begin
        if (rd_pend_q && sched_io.fifo_q[0]) begin
          // Premature header truncates this block and becomes the next one.
          err_evt_c = 1'b1;
          active_d  = 1'b0;
          bs_d      = sched_io.fifo_q[1];
          byte0_d   = sched_io.fifo_q[9:2];
          state_d   = S_WAIT_RES;
        end else begin
          if (!sched_io.fifo_empty && (issued_q < n_c)) begin
            rdreq_c  = 1'b1;
            issued_d = issued_q + CNT_W'(1);
          end
          if (rd_pend_q) begin
            enc_din_d   = sched_io.fifo_q[9:2];
            enc_valid_d = 1'b1;
            sent_d      = sent_q + CNT_W'(1);
            if (sched_io.fifo_q[1] != bs_q) begin
              err_evt_c = 1'b1;
            end
            if (last_c) begin
              state_d = S_IDLE;
            end
          end
        end
      end

      default: state_d = S_IDLE;
    endcase

    if (issue_c) begin
      enc_start_d = 1'b1;
      enc_valid_d = 1'b1;
      enc_din_d   = issue_byte_c;
      enc_bs_d    = issue_bs_c;
      active_d    = 1'b1;
      sent_d      = CNT_W'(1);
      issued_d    = CNT_W'(1);
      state_d     = S_STREAM;
    end

    if (err_evt_c) begin
      err_d = 1'b1;
    end
  end

  // FIFO read strobe is combinational so it can never fire on a stale empty flag.
  assign sched_io.fifo_rdreq = rdreq_c && reset;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      bs_q        <= 1'b0;
      byte0_q     <= '0;
      issued_q    <= '0;
      sent_q      <= '0;
      err_q       <= 1'b0;
      rd_pend_q   <= 1'b0;
      enc_start_q <= 1'b0;
      enc_bs_q    <= 1'b0;
      enc_din_q   <= '0;
      enc_valid_q <= 1'b0;
      active_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      bs_q        <= bs_d;
      byte0_q     <= byte0_d;
      issued_q    <= issued_d;
      sent_q      <= sent_d;
      err_q       <= err_d;
      rd_pend_q   <= sched_io.fifo_rdreq;
      enc_start_q <= enc_start_d;
      enc_bs_q    <= enc_bs_d;
      enc_din_q   <= enc_din_d;
      enc_valid_q <= enc_valid_d;
      active_q    <= active_d;
    end
  end

  assign sched_io.enc_start     = enc_start_q;
  assign sched_io.enc_blocksize = enc_bs_q;
  assign sched_io.enc_din       = enc_din_q;
  assign sched_io.enc_din_valid = enc_valid_q;
  assign sched_io.block_active  = active_q;
  assign sched_io.sched_err     = err_q;

`ifdef CB_SCHED_STATS_EN
  logic [15:0] blocks_q, blocks_d;
  logic [7:0]  errcnt_q, errcnt_d;

  // Completed-block counter wraps; error counter saturates.
  always_comb begin
    blocks_d = blocks_q;
    errcnt_d = errcnt_q;
    if (last_c) begin
      blocks_d = blocks_q + 16'd1;
    end
    if (err_evt_c && (errcnt_q != 8'hFF)) begin
      errcnt_d = errcnt_q + 8'd1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      blocks_q <= '0;
      errcnt_q <= '0;
    end else begin
      blocks_q <= blocks_d;
      errcnt_q <= errcnt_d;
    end
  end

  assign blocks_done = blocks_q;
  assign err_count   = errcnt_q;
`else
  // Statistics counters are absent in the default build.
`endif

endmodule

// File: tb/tb_encoder_cb_scheduler.sv
// Scoreboard bench for encoder_cb_scheduler: FIFO model feeds framed words, expected bytes are queued
// at push time and popped as the encoder-side outputs appear.
module tb_encoder_cb_scheduler;

  logic clock = 1'b0;
  logic reset = 1'b0;

  always #5 clock = ~clock;

  encoder_cb_scheduler_if bus ();

`ifdef CB_SCHED_STATS_EN
  logic [15:0] blocks_done;
  logic [7:0]  err_count;
`endif

  encoder_cb_scheduler dut (
    .clock       (clock),
    .reset       (reset),
    .sched_io    (bus)
`ifdef CB_SCHED_STATS_EN
    ,
    .blocks_done (blocks_done),
    .err_count   (err_count)
`endif
  );

  typedef struct {
    logic [7:0] d;
    logic       first;
    logic       bs;
    logic       last;
  } exp_t;

  exp_t       exp_q[$];
  logic [9:0] fifo_mem[$];

  int n_checks = 0;
  int n_fail   = 0;
  int pushed   = 0;
  int popped   = 0;
  int cyc      = 0;
  int rd_cnt   = 0;
  int start_cnt = 0;
  int valid_cnt = 0;
  int gap_cnt   = 0;
  int last_end_cyc = 0;
  int start_gap    = 0;
  logic rd_seen    = 1'b0;
  logic empty_seen = 1'b1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Non-show-ahead FIFO model: strobe sampled just before the edge, data appears after it.
  assign bus.fifo_empty = (pushed == popped);

  always begin
    @(negedge clock);
    #4;
    rd_seen    = bus.fifo_rdreq;
    empty_seen = bus.fifo_empty;
  end

  always @(posedge clock) begin
    cyc++;
    if (rd_seen) begin
      rd_cnt++;
      chk("rd_when_empty", 32'(empty_seen), 32'd0);
      if (fifo_mem.size() != 0) begin
        bus.fifo_q <= fifo_mem.pop_front();
        popped++;
      end
    end
  end

  // Output monitor / scoreboard consumer.
  always @(negedge clock) begin
    exp_t e;
    if (reset) begin
      if (bus.block_active && !bus.enc_din_valid) gap_cnt++;
      if (bus.enc_start) begin
        start_cnt++;
        start_gap = cyc - last_end_cyc;
        chk("start_has_valid", 32'(bus.enc_din_valid), 32'd1);
      end
      if (bus.enc_din_valid) begin
        valid_cnt++;
        chk("active_with_valid", 32'(bus.block_active), 32'd1);
        if (exp_q.size() == 0) begin
          chk("unexpected_byte", 32'(bus.enc_din_valid), 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("din", 32'(bus.enc_din), 32'(e.d));
          chk("start_flag", 32'(bus.enc_start), 32'(e.first));
          chk("blocksize", 32'(bus.enc_blocksize), 32'(e.bs));
          if (e.last) last_end_cyc = cyc;
        end
      end
    end
  end

  task automatic push_blk(input int n_words, input logic bs, input int full_n, input bit paced);
    logic [7:0] d;
    exp_t       e;
    for (int i = 0; i < n_words; i++) begin
      d = 8'($urandom);
      fifo_mem.push_back({d, bs, (i == 0)});
      pushed++;
      e.d     = d;
      e.first = (i == 0);
      e.bs    = bs;
      e.last  = (i == full_n - 1);
      exp_q.push_back(e);
      if (paced) begin
        @(negedge clock);
        if ((i % 10) == 9) repeat (5) @(negedge clock);
      end
    end
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int k;
    k = 0;
    while ((exp_q.size() != 0 || fifo_mem.size() != 0 || bus.block_active) && k < budget) begin
      @(negedge clock);
      k++;
    end
    chk(tag, 32'(k < budget), 32'd1);
    repeat (4) @(negedge clock);
  endtask

  task automatic do_reset();
    @(negedge clock);
    #2 reset = 1'b0;
    fifo_mem.delete();
    exp_q.delete();
    pushed = popped;
    repeat (3) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
  endtask

  initial begin
    int k;
    int rd_base, st_base, vl_base, gp_base;
    bus.int_ready = 1'b1;
    bus.enc_busy  = 1'b0;
    repeat (3) @(negedge clock);

    // Reset state
    chk("rst_outputs", 32'({bus.enc_start, bus.enc_blocksize, bus.enc_din, bus.enc_din_valid,
                            bus.block_active, bus.sched_err, bus.fifo_rdreq}), 32'd0);
`ifdef CB_SCHED_STATS_EN
    chk("rst_stats", 32'({blocks_done, err_count}), 32'd0);
`endif
    reset = 1'b1;
    @(negedge clock);

    // Single small block, resources free
    rd_base = rd_cnt; st_base = start_cnt; vl_base = valid_cnt;
    push_blk(132, 1'b0, 132, 1'b0);
    wait_drain("t2_drain", 2000);
    chk("t2_starts", 32'(start_cnt - st_base), 32'd1);
    chk("t2_valids", 32'(valid_cnt - vl_base), 32'd132);
    chk("t2_rdreqs", 32'(rd_cnt - rd_base), 32'd132);
    chk("t2_err", 32'(bus.sched_err), 32'd0);

    // Large block held off by enc_busy
    rd_base = rd_cnt; st_base = start_cnt; vl_base = valid_cnt;
    bus.enc_busy = 1'b1;
    push_blk(768, 1'b1, 768, 1'b0);
    k = 0;
    while (rd_cnt == rd_base && k < 50) begin
      @(negedge clock);
      k++;
    end
    chk("t3_hdr_read", 32'(rd_cnt - rd_base), 32'd1);
    repeat (20) @(negedge clock);
    chk("t3_no_early_start", 32'(start_cnt - st_base), 32'd0);
    chk("t3_no_rd_in_wait", 32'(rd_cnt - rd_base), 32'd1);
    bus.enc_busy = 1'b0;
    @(negedge clock);
    chk("t3_start_after_busy", 32'(bus.enc_start), 32'd1);
    wait_drain("t3_drain", 4000);
    chk("t3_starts", 32'(start_cnt - st_base), 32'd1);
    chk("t3_valids", 32'(valid_cnt - vl_base), 32'd768);
    chk("t3_rdreqs", 32'(rd_cnt - rd_base), 32'd768);

    // FIFO underrun: paced bursts of 10 words with 5-cycle holes
    rd_base = rd_cnt; vl_base = valid_cnt; gp_base = gap_cnt;
    push_blk(132, 1'b0, 132, 1'b1);
    wait_drain("t4_drain", 2000);
    chk("t4_valids", 32'(valid_cnt - vl_base), 32'd132);
    chk("t4_rdreqs", 32'(rd_cnt - rd_base), 32'd132);
    chk("t4_gaps_seen", 32'((gap_cnt - gp_base) > 5), 32'd1);
    chk("t4_err", 32'(bus.sched_err), 32'd0);

    // Framing errors: stray word, then truncation by an early header at byte 50
    do_reset();
    rd_base = rd_cnt; st_base = start_cnt; vl_base = valid_cnt;
    fifo_mem.push_back({8'hA5, 1'b0, 1'b0});
    pushed++;
    repeat (6) @(negedge clock);
    chk("t5_stray_err", 32'(bus.sched_err), 32'd1);
    chk("t5_stray_no_out", 32'(valid_cnt - vl_base), 32'd0);
    chk("t5_stray_read", 32'(rd_cnt - rd_base), 32'd1);
    push_blk(50, 1'b0, 132, 1'b0);
    push_blk(132, 1'b0, 132, 1'b0);
    wait_drain("t5_drain", 2000);
    chk("t5_starts", 32'(start_cnt - st_base), 32'd2);
    chk("t5_valids", 32'(valid_cnt - vl_base), 32'd182);
    chk("t5_err_sticky", 32'(bus.sched_err), 32'd1);
`ifdef CB_SCHED_STATS_EN
    chk("t5_err_count", 32'(err_count), 32'd2);
    chk("t5_blocks_done", 32'(blocks_done), 32'd1);
`endif

    // Back-to-back small blocks
    do_reset();
    st_base = start_cnt; vl_base = valid_cnt;
    push_blk(132, 1'b0, 132, 1'b0);
    push_blk(132, 1'b0, 132, 1'b0);
    wait_drain("t6_drain", 2000);
    chk("t6_starts", 32'(start_cnt - st_base), 32'd2);
    chk("t6_valids", 32'(valid_cnt - vl_base), 32'd264);
    chk("t6_b2b_gap_le3", 32'(start_gap <= 3), 32'd1);
    chk("t6_err", 32'(bus.sched_err), 32'd0);
`ifdef CB_SCHED_STATS_EN
    chk("t6_blocks_done", 32'(blocks_done), 32'd2);
`endif

    // Reset in the middle of a block
    vl_base = valid_cnt;
    push_blk(132, 1'b0, 132, 1'b0);
    k = 0;
    while ((valid_cnt - vl_base) < 20 && k < 200) begin
      @(negedge clock);
      k++;
    end
    chk("t1_midblock_reached", 32'(bus.block_active), 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("t1_async_outputs", 32'({bus.enc_start, bus.enc_blocksize, bus.enc_din, bus.enc_din_valid,
                                 bus.block_active, bus.sched_err, bus.fifo_rdreq}), 32'd0);
    fifo_mem.delete();
    exp_q.delete();
    pushed = popped;
    repeat (3) @(negedge clock);
    reset = 1'b1;
    rd_base = rd_cnt;
    repeat (10) @(negedge clock);
    chk("t1_no_rd_empty", 32'(rd_cnt - rd_base), 32'd0);
    chk("t1_idle_active", 32'(bus.block_active), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
